// File: rtl/command_credit_arbiter_pkg.sv
// Shared globals for the command credit arbiter: credit pool sizes,
// counter widths, the credit-class encoding and the arbiter state type.
package command_credit_arbiter_pkg;

  localparam int CREDITS_READ  = 32;
  localparam int CREDITS_WRITE = 32;
  localparam int CREDITS_TOTAL = CREDITS_READ + CREDITS_WRITE;

  localparam int TOTAL_W = 7;
  localparam int POOL_W  = 6;

  typedef enum logic [1:0] {
    CLS_WED     = 2'd0,
    CLS_RESTART = 2'd1,
    CLS_READ    = 2'd2,
    CLS_WRITE   = 2'd3
  } credit_class_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } arb_state_t;

  // The command room offered by PSL is capped at the configured global credit limit.
  function automatic logic [TOTAL_W-1:0] clamp_room(input logic [7:0] room,
                                                    input logic [TOTAL_W-1:0] cap);
    logic [7:0] cap_ext;
    cap_ext = {1'b0, cap};
    if (room > cap_ext) begin
      return cap;
    end else begin
      return room[TOTAL_W-1:0];
    end
  endfunction

endpackage

// File: rtl/command_credit_arbiter_counter.sv
// Credit counter: loads a full value, counts grants down and returns up,
// saturating at its full value and flagging any over-return.
module credit_counter
  import command_credit_arbiter_pkg::*;
#(
  parameter int W = TOTAL_W
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         at_full,
  output logic         over
);

  logic [W-1:0] count_r;
  logic [W-1:0] full_r;

  assign count   = count_r;
  assign at_full = (count_r == full_r);
  // A lone return on a counter already at its full value is an over-return.
  assign over    = inc & ~dec & (count_r >= full_r);

  // Count register with load, saturating increment and guarded decrement.
  always_ff @(posedge clock) begin
    if (reset) begin
      count_r <= {W{1'b0}};
      full_r  <= {W{1'b0}};
    end else if (load) begin
      count_r <= load_value;
      full_r  <= load_value;
    end else begin
      case ({inc, dec})
        2'b10: begin
          if (count_r < full_r) begin
            count_r <= count_r + {{(W-1){1'b0}}, 1'b1};
          end else begin
            count_r <= count_r;
          end
        end
        2'b01: begin
          if (count_r != {W{1'b0}}) begin
            count_r <= count_r - {{(W-1){1'b0}}, 1'b1};
          end else begin
            count_r <= count_r;
          end
        end
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/command_credit_arbiter.sv
// Command credit arbiter: grants WED/RESTART/READ/WRITE commands against a
// global credit pool plus read and write pools, and drains on job disable.
module command_credit_arbiter #(
  parameter int CREDITS_READ  = command_credit_arbiter_pkg::CREDITS_READ,
  parameter int CREDITS_WRITE = command_credit_arbiter_pkg::CREDITS_WRITE,
  parameter int CREDITS_TOTAL = CREDITS_READ + CREDITS_WRITE
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enabled_in,
  input  logic       room_load,
  input  logic [7:0] room_value,
  input  logic [3:0] req_valid,
  input  logic       rsp_valid,
  input  logic [1:0] rsp_class,
  output logic [3:0] grant_out,
  output logic [6:0] credits_total_out,
  output logic [5:0] credits_read_out,
  output logic [5:0] credits_write_out,
  output logic       drained_out,
  output logic       credit_error_out
);

  import command_credit_arbiter_pkg::*;

  arb_state_t          state_r;
  arb_state_t          state_next_s;
  logic [3:0]          grant_r;
  logic [3:0]          grant_s;
  logic [3:0]          elig_s;
  logic                rr_r;
  logic                error_r;
  logic                drained_r;

  logic [TOTAL_W-1:0]  total_s;
  logic [POOL_W-1:0]   read_s;
  logic [POOL_W-1:0]   write_s;
  logic                total_full_s;
  logic                read_full_s;
  logic                write_full_s;
  logic                total_over_s;
  logic                read_over_s;
  logic                write_over_s;

  logic                load_s;
  logic                rsp_ok_s;
  logic [TOTAL_W-1:0]  total_load_s;
  credit_class_t       rsp_cls_s;

  assign rsp_cls_s    = credit_class_t'(rsp_class);
  assign load_s       = (state_r == ST_IDLE) & room_load & enabled_in;
  assign rsp_ok_s     = rsp_valid & (state_r != ST_IDLE);
  assign total_load_s = clamp_room(room_value, TOTAL_W'(CREDITS_TOTAL));

  credit_counter #(.W(TOTAL_W)) u_total (
    .clock      (clock),
    .reset      (reset),
    .load       (load_s),
    .load_value (total_load_s),
    .inc        (rsp_ok_s),
    .dec        (|grant_s),
    .count      (total_s),
    .at_full    (total_full_s),
    .over       (total_over_s)
  );

  credit_counter #(.W(POOL_W)) u_read (
    .clock      (clock),
    .reset      (reset),
    .load       (load_s),
    .load_value (POOL_W'(CREDITS_READ)),
    .inc        (rsp_ok_s & (rsp_cls_s == CLS_READ)),
    .dec        (grant_s[2]),
    .count      (read_s),
    .at_full    (read_full_s),
    .over       (read_over_s)
  );

  credit_counter #(.W(POOL_W)) u_write (
    .clock      (clock),
    .reset      (reset),
    .load       (load_s),
    .load_value (POOL_W'(CREDITS_WRITE)),
    .inc        (rsp_ok_s & (rsp_cls_s == CLS_WRITE)),
    .dec        (grant_s[3]),
    .count      (write_s),
    .at_full    (write_full_s),
    .over       (write_over_s)
  );

  assign elig_s[0] = req_valid[0] & (total_s != 7'd0);
  assign elig_s[1] = req_valid[1] & (total_s != 7'd0);
  assign elig_s[2] = req_valid[2] & (total_s != 7'd0) & (read_s  != 6'd0);
  assign elig_s[3] = req_valid[3] & (total_s != 7'd0) & (write_s != 6'd0);

  // Fixed priority for WED and RESTART, round-robin between READ and WRITE.
  always_comb begin
    grant_s = 4'b0000;
    if ((state_r == ST_RUN) && enabled_in) begin
      if (elig_s[0]) begin
        grant_s = 4'b0001;
      end else if (elig_s[1]) begin
        grant_s = 4'b0010;
      end else if (elig_s[2] && elig_s[3]) begin
        grant_s = rr_r ? 4'b1000 : 4'b0100;
      end else if (elig_s[2]) begin
        grant_s = 4'b0100;
      end else if (elig_s[3]) begin
        grant_s = 4'b1000;
      end else begin
        grant_s = 4'b0000;
      end
    end else begin
      grant_s = 4'b0000;
    end
  end

  // Next-state logic for the job lifecycle.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (room_load && enabled_in) begin
          state_next_s = ST_RUN;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (!enabled_in) begin
          state_next_s = ST_DRAIN;
        end else begin
          state_next_s = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (total_full_s && read_full_s && write_full_s) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_DRAIN;
        end
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // State, grant, pointer and status registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      grant_r   <= 4'b0000;
      rr_r      <= 1'b0;
      error_r   <= 1'b0;
      drained_r <= 1'b1;
    end else begin
      state_r   <= state_next_s;
      grant_r   <= grant_s;
      // IDLE is only reached with every counter at its full value.
      drained_r <= (state_next_s == ST_IDLE);
      error_r   <= error_r | total_over_s | read_over_s | write_over_s |
                   (rsp_valid & (state_r == ST_IDLE));
      // Point away from whichever of READ/WRITE was just served.
      if (grant_s[2]) begin
        rr_r <= 1'b1;
      end else if (grant_s[3]) begin
        rr_r <= 1'b0;
      end else begin
        rr_r <= rr_r;
      end
    end
  end

  assign grant_out         = grant_r;
  assign credits_total_out = total_s;
  assign credits_read_out  = read_s;
  assign credits_write_out = write_s;
  assign drained_out       = drained_r;
  assign credit_error_out  = error_r;

endmodule

// File: tb/tb_command_credit_arbiter.sv
// Directed self-checking bench for command_credit_arbiter.
module tb_command_credit_arbiter;

  logic       clock = 1'b0;
  logic       reset;
  logic       enabled_in;
  logic       room_load;
  logic [7:0] room_value;
  logic [3:0] req_valid;
  logic       rsp_valid;
  logic [1:0] rsp_class;
  logic [3:0] grant_out;
  logic [6:0] credits_total_out;
  logic [5:0] credits_read_out;
  logic [5:0] credits_write_out;
  logic       drained_out;
  logic       credit_error_out;

  int tests = 0;
  int fails = 0;
  int gcnt;
  int badcnt;
  logic [3:0] exp_g;

  command_credit_arbiter dut (
    .clock             (clock),
    .reset             (reset),
    .enabled_in        (enabled_in),
    .room_load         (room_load),
    .room_value        (room_value),
    .req_valid         (req_valid),
    .rsp_valid         (rsp_valid),
    .rsp_class         (rsp_class),
    .grant_out         (grant_out),
    .credits_total_out (credits_total_out),
    .credits_read_out  (credits_read_out),
    .credits_write_out (credits_write_out),
    .drained_out       (drained_out),
    .credit_error_out  (credit_error_out)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic load_room(input logic [7:0] v);
    enabled_in = 1'b1;
    room_load  = 1'b1;
    room_value = v;
    tick();
    room_load  = 1'b0;
  endtask

  initial begin
    reset = 1'b1; enabled_in = 1'b0; room_load = 1'b0; room_value = 8'd0;
    req_valid = 4'b0000; rsp_valid = 1'b0; rsp_class = 2'd0;
    tick(); tick();
    chk("rst_grant", grant_out, 4'b0000);
    chk("rst_total", credits_total_out, 7'd0);
    chk("rst_read", credits_read_out, 6'd0);
    chk("rst_write", credits_write_out, 6'd0);
    chk("rst_drained", drained_out, 1'b1);
    chk("rst_error", credit_error_out, 1'b0);
    reset = 1'b0;

    // Room 100 clamps to 64; READ held 40 cycles exhausts the read pool.
    load_room(8'd100);
    chk("load_total", credits_total_out, 7'd64);
    chk("load_read", credits_read_out, 6'd32);
    chk("load_write", credits_write_out, 6'd32);
    chk("run_drained", drained_out, 1'b0);
    req_valid = 4'b0100; gcnt = 0; badcnt = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (grant_out == 4'b0100) gcnt++;
      else if (grant_out != 4'b0000) badcnt++;
    end
    req_valid = 4'b0000;
    chk("read40_grants", gcnt, 32);
    chk("read40_bad", badcnt, 0);
    chk("read40_read", credits_read_out, 6'd0);
    chk("read40_total", credits_total_out, 7'd32);
    chk("read40_write", credits_write_out, 6'd32);

    room_load = 1'b1; room_value = 8'd5;
    tick();
    room_load = 1'b0;
    chk("load_ignored", credits_total_out, 7'd32);

    // Reset mid-RUN with a request held.
    req_valid = 4'b0001;
    reset = 1'b1;
    tick();
    chk("midrst_grant", grant_out, 4'b0000);
    chk("midrst_total", credits_total_out, 7'd0);
    chk("midrst_drained", drained_out, 1'b1);
    reset = 1'b0;
    tick();
    chk("postrst_grant", grant_out, 4'b0000);
    req_valid = 4'b0000;

    // Room 10 with READ+WRITE held: alternating grants, then none.
    load_room(8'd10);
    chk("r10_total", credits_total_out, 7'd10);
    req_valid = 4'b1100;
    for (int i = 0; i < 14; i++) begin
      tick();
      if (i >= 10) exp_g = 4'b0000;
      else if (i % 2 == 0) exp_g = 4'b0100;
      else exp_g = 4'b1000;
      chk($sformatf("rr_%0d", i), grant_out, exp_g);
    end
    req_valid = 4'b0000;
    chk("r10_total_end", credits_total_out, 7'd0);
    chk("r10_read_end", credits_read_out, 6'd27);
    chk("r10_write_end", credits_write_out, 6'd27);
    req_valid = 4'b0001;
    tick();
    chk("wed_no_total", grant_out, 4'b0000);
    req_valid = 4'b0000;

    // Priority WED > RESTART > READ.
    do_reset();
    load_room(8'd200);
    chk("clamp_total", credits_total_out, 7'd64);
    req_valid = 4'b0111;
    tick();
    chk("prio_wed", grant_out, 4'b0001);
    req_valid = 4'b0110;
    tick();
    chk("prio_restart", grant_out, 4'b0010);
    req_valid = 4'b0100;
    tick();
    chk("prio_read", grant_out, 4'b0100);
    req_valid = 4'b0000;
    tick();
    chk("prio_pulse", grant_out, 4'b0000);
    chk("prio_total", credits_total_out, 7'd61);
    chk("prio_read_cnt", credits_read_out, 6'd31);

    // Bring read pool to 5, then grant and return READ in the same cycle.
    req_valid = 4'b0100;
    for (int i = 0; i < 26; i++) tick();
    req_valid = 4'b0000;
    chk("pre_net_read", credits_read_out, 6'd5);
    chk("pre_net_total", credits_total_out, 7'd35);
    req_valid = 4'b0100; rsp_valid = 1'b1; rsp_class = 2'd2;
    tick();
    req_valid = 4'b0000; rsp_valid = 1'b0;
    chk("net_grant", grant_out, 4'b0100);
    chk("net_read", credits_read_out, 6'd5);
    chk("net_total", credits_total_out, 7'd35);
    chk("net_error", credit_error_out, 1'b0);

    // Drain with 3 outstanding credits.
    do_reset();
    load_room(8'd64);
    req_valid = 4'b0100; tick();
    req_valid = 4'b1000; tick();
    req_valid = 4'b0001; tick();
    req_valid = 4'b0000;
    chk("drn_total", credits_total_out, 7'd61);
    enabled_in = 1'b0; req_valid = 4'b1111;
    tick();
    chk("drn_grant0", grant_out, 4'b0000);
    rsp_valid = 1'b1; rsp_class = 2'd2;
    tick();
    chk("drn_grant1", grant_out, 4'b0000);
    rsp_class = 2'd3;
    tick();
    chk("drn_grant2", grant_out, 4'b0000);
    chk("drn_not_drained", drained_out, 1'b0);
    rsp_class = 2'd0;
    tick();
    chk("drn_grant3", grant_out, 4'b0000);
    rsp_valid = 1'b0;
    tick();
    req_valid = 4'b0000;
    chk("drn_drained", drained_out, 1'b1);
    chk("drn_total_full", credits_total_out, 7'd64);
    chk("drn_read_full", credits_read_out, 6'd32);
    chk("drn_write_full", credits_write_out, 6'd32);
    chk("drn_error", credit_error_out, 1'b0);
    rsp_valid = 1'b1; rsp_class = 2'd0;
    tick();
    rsp_valid = 1'b0;
    chk("idle_rsp_error", credit_error_out, 1'b1);
    chk("idle_rsp_total", credits_total_out, 7'd64);

    // Over-return on full pools.
    do_reset();
    chk("err_cleared", credit_error_out, 1'b0);
    load_room(8'd64);
    rsp_valid = 1'b1; rsp_class = 2'd3;
    tick();
    rsp_valid = 1'b0;
    chk("over_write", credits_write_out, 6'd32);
    chk("over_total", credits_total_out, 7'd64);
    chk("over_error", credit_error_out, 1'b1);
    tick(); tick(); tick();
    chk("over_sticky", credit_error_out, 1'b1);
    do_reset();
    chk("over_reset", credit_error_out, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
